// File: rtl/axi_ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_ddr_rd_arbiter
// Description : Round-robin arbiter sharing one single-outstanding AXI read
//               slave (AR/R channels) among NUM_M read masters. One burst is
//               in flight at a time; R beats are routed to the granted master
//               and the burst length is cross-checked against RLAST.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ddr_rd_arbiter #(
    parameter  int NUM_M          = 2,
    parameter  int AXI_ID_WIDTH   = 4,
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_DATA_WIDTH = 64,
    localparam int GW             = $clog2(NUM_M)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // master-side AR (packed, master i at slice i)
    input  logic [NUM_M*AXI_ID_WIDTH-1:0]     m_arid,
    input  logic [NUM_M*AXI_ADDR_WIDTH-1:0]   m_araddr,
    input  logic [NUM_M*8-1:0]                m_arlen,
    input  logic [NUM_M-1:0]                  m_arvalid,
    output logic [NUM_M-1:0]                  m_arready,
    // master-side R (shared payload, per-master handshake)
    output logic [AXI_ID_WIDTH-1:0]           m_rid,
    output logic [AXI_DATA_WIDTH-1:0]         m_rdata,
    output logic [1:0]                        m_rresp,
    output logic                              m_rlast,
    output logic [NUM_M-1:0]                  m_rvalid,
    input  logic [NUM_M-1:0]                  m_rready,
    // slave-side AR
    output logic [AXI_ID_WIDTH-1:0]           s_arid,
    output logic [AXI_ADDR_WIDTH-1:0]         s_araddr,
    output logic [7:0]                        s_arlen,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    // slave-side R
    input  logic [AXI_ID_WIDTH-1:0]           s_rid,
    input  logic [AXI_DATA_WIDTH-1:0]         s_rdata,
    input  logic [1:0]                        s_rresp,
    input  logic                              s_rlast,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    // status
    output logic [GW-1:0]                     grant_idx,
    output logic                              busy,
    output logic                              proto_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] w_sel;
    logic [GW-1:0] w_scan;
    logic          w_any;
    logic [8:0]    r_beat_cnt;
    logic          r_proto_err;
    logic          w_ar_hs;
    logic          w_r_hs;

    assign w_ar_hs = s_arvalid && s_arready;
    assign w_r_hs  = s_rvalid && s_rready;

    // Round-robin pick: first requester after the last served master, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = r_last_grant;
        w_scan = r_last_grant;
        for (int k = 0; k < NUM_M; k++) begin
            w_scan = (w_scan == GW'(NUM_M - 1)) ? '0 : w_scan + GW'(1);
            if (!w_any && m_arvalid[w_scan]) begin
                w_any = 1'b1;
                w_sel = w_scan;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one burst at a time, always returning through IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any)              w_next_state = S_ADDR;
            S_ADDR:  if (w_ar_hs)            w_next_state = S_DATA;
            S_DATA:  if (w_r_hs && s_rlast)  w_next_state = S_IDLE;
            default:                         w_next_state = S_IDLE;
        endcase
    end

    // Output logic: AR muxed from the granted slice, R steered to the grantee.
    always_comb begin
        s_arvalid = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        s_arid    = m_arid[int'(r_grant)*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        s_araddr  = m_araddr[int'(r_grant)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        s_arlen   = m_arlen[int'(r_grant)*8 +: 8];
        case (r_state)
            S_ADDR: begin
                s_arvalid          = 1'b1;
                m_arready[r_grant] = s_arready;
            end
            S_DATA: begin
                m_rvalid[r_grant] = s_rvalid;
                s_rready          = m_rready[r_grant];
            end
            default: ;
        endcase
    end

    // Grant bookkeeping, beat counter and sticky length-mismatch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_M - 1);
            r_beat_cnt   <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_sel;
            end
            if (r_state == S_ADDR && w_ar_hs) begin
                r_beat_cnt <= {1'b0, s_arlen} + 9'd1;
            end else if (r_state == S_DATA && w_r_hs) begin
                r_beat_cnt <= r_beat_cnt - 9'd1;
            end
            if (r_state == S_DATA && w_r_hs && s_rlast) begin
                r_last_grant <= r_grant;
            end
            // rlast must coincide exactly with the final counted beat
            if (r_state == S_DATA && w_r_hs && (s_rlast != (r_beat_cnt == 9'd1))) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign m_rid     = s_rid;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;
    assign grant_idx = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ddr_rd_arbiter
// Description : Self-checking bench for axi_ddr_rd_arbiter with a DDR read
//               slave stub and a cycle-level reference of the arbitration
//               and routing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ddr_rd_arbiter;

    localparam int NUM_M  = 2;
    localparam int IDW    = 4;
    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int GW     = 1;
    localparam int RD_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NUM_M*IDW-1:0] m_arid;
    logic [NUM_M*AW-1:0]  m_araddr;
    logic [NUM_M*8-1:0]   m_arlen;
    logic [NUM_M-1:0]     m_arvalid;
    logic [NUM_M-1:0]     m_arready;
    logic [IDW-1:0]       m_rid;
    logic [DW-1:0]        m_rdata;
    logic [1:0]           m_rresp;
    logic                 m_rlast;
    logic [NUM_M-1:0]     m_rvalid;
    logic [NUM_M-1:0]     m_rready;
    logic [IDW-1:0]       s_arid;
    logic [AW-1:0]        s_araddr;
    logic [7:0]           s_arlen;
    logic                 s_arvalid;
    logic                 s_arready;
    logic [IDW-1:0]       s_rid;
    logic [DW-1:0]        s_rdata;
    logic [1:0]           s_rresp;
    logic                 s_rlast;
    logic                 s_rvalid;
    logic                 s_rready;
    logic [GW-1:0]        grant_idx;
    logic                 busy;
    logic                 proto_err;

    always #5 clk = ~clk;

    axi_ddr_rd_arbiter #(
        .NUM_M(NUM_M), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant_idx(grant_idx), .busy(busy), .proto_err(proto_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- DDR read slave stub ----------------
    logic [63:0] mem [0:255];
    int          early_idx = -1;   // >=0: return rlast on this beat index
    logic        gap_mode  = 1'b0; // random AR/R stalls from the slave
    logic        sl_busy;
    int          sl_lat;
    int          sl_beat;
    int          sl_len;
    logic [AW-1:0]  sl_addr;
    logic [IDW-1:0] sl_id;
    logic        sl_rv;
    logic        sl_ar_ok;

    assign s_arready = !sl_busy && sl_ar_ok;
    assign s_rvalid  = sl_busy && (sl_lat == 0) && sl_rv;
    assign s_rdata   = mem[(int'(sl_addr >> 3) + sl_beat) & 255];
    assign s_rlast   = sl_busy && (sl_beat == ((early_idx >= 0) ? early_idx : sl_len));
    assign s_rid     = sl_id;
    assign s_rresp   = sl_id[1:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_busy  <= 1'b0;
            sl_lat   <= 0;
            sl_beat  <= 0;
            sl_len   <= 0;
            sl_addr  <= '0;
            sl_id    <= '0;
            sl_rv    <= 1'b1;
            sl_ar_ok <= 1'b1;
        end else begin
            sl_ar_ok <= gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!(s_rvalid && !s_rready))
                sl_rv <= gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!sl_busy) begin
                if (s_arvalid && s_arready) begin
                    sl_busy <= 1'b1;
                    sl_lat  <= RD_LAT;
                    sl_beat <= 0;
                    sl_len  <= int'(s_arlen);
                    sl_addr <= s_araddr;
                    sl_id   <= s_arid;
                end
            end else if (sl_lat > 0) begin
                sl_lat <= sl_lat - 1;
            end else if (s_rvalid && s_rready) begin
                if (s_rlast) sl_busy <= 1'b0;
                else         sl_beat <= sl_beat + 1;
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    // ph: 0 waiting for requests, 1 address offered, 2 beats flowing
    int          ph = 0, cur = 0, last = NUM_M - 1, beat = 0, len = 0;
    logic [AW-1:0]  b_addr = '0;
    logic [IDW-1:0] b_id   = '0;
    logic        exp_err = 1'b0;
    int          bursts_done = 0;
    int          n_grants = 0;
    int          grant_log [0:255];
    int          rx_cnt = 0;
    logic [63:0] rx_data [0:1023];
    int          rx_m    [0:1023];
    logic        rx_last [0:1023];

    always @(negedge clk) begin
        logic [NUM_M-1:0] e_ar;
        logic [NUM_M-1:0] e_rv;
        logic             found;
        if (!rst_n) begin
            ph = 0; cur = 0; last = NUM_M - 1; beat = 0; exp_err = 1'b0;
            check("rst_s_arvalid", s_arvalid, 0);
            check("rst_m_rvalid", m_rvalid, 0);
            check("rst_s_rready", s_rready, 0);
            check("rst_busy", busy, 0);
        end else begin
            e_ar = '0;
            e_rv = '0;
            if (ph == 1 && s_arready) e_ar[cur] = 1'b1;
            if (ph == 2 && s_rvalid)  e_rv[cur] = 1'b1;
            check("grant_idx", grant_idx, cur);
            check("busy", busy, ph != 0);
            check("proto_err", proto_err, exp_err);
            check("s_arvalid", s_arvalid, ph == 1);
            check("m_arready", m_arready, e_ar);
            check("m_rvalid", m_rvalid, e_rv);
            check("s_rready", s_rready, (ph == 2) ? m_rready[cur] : 1'b0);
            if (ph == 1) begin
                check("s_araddr", s_araddr, m_araddr[cur*AW +: AW]);
                check("s_arlen", s_arlen, m_arlen[cur*8 +: 8]);
                check("s_arid", s_arid, m_arid[cur*IDW +: IDW]);
            end
            if (ph == 2 && s_rvalid) begin
                check("m_rdata", m_rdata, mem[(int'(b_addr >> 3) + beat) & 255]);
                check("m_rid", m_rid, b_id);
                check("m_rresp", m_rresp, b_id[1:0]);
                check("m_rlast", m_rlast, (early_idx >= 0) ? (beat == early_idx) : (beat == len));
            end
            // advance the model by the handshakes that the next edge will take
            case (ph)
                0: if (|m_arvalid) begin
                    found = 1'b0;
                    for (int k = 1; k <= NUM_M; k++) begin
                        if (!found && m_arvalid[(last + k) % NUM_M]) begin
                            cur   = (last + k) % NUM_M;
                            found = 1'b1;
                        end
                    end
                    grant_log[n_grants % 256] = cur;
                    n_grants++;
                    ph = 1;
                end
                1: if (s_arready) begin
                    ph     = 2;
                    beat   = 0;
                    len    = int'(m_arlen[cur*8 +: 8]);
                    b_addr = m_araddr[cur*AW +: AW];
                    b_id   = m_arid[cur*IDW +: IDW];
                end
                default: if (s_rvalid && m_rready[cur]) begin
                    if (s_rlast != (beat == len)) exp_err = 1'b1;
                    rx_data[rx_cnt % 1024] = m_rdata;
                    rx_m[rx_cnt % 1024]    = cur;
                    rx_last[rx_cnt % 1024] = m_rlast;
                    rx_cnt++;
                    beat++;
                    if (s_rlast) begin
                        ph = 0;
                        last = cur;
                        bursts_done++;
                    end
                end
            endcase
        end
    end

    // ---------------- master-side driver ----------------
    typedef struct {
        int             m;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [IDW-1:0] id;
    } req_t;

    req_t pend [$];
    int   rr_mode = 0;   // 0: always ready, 1: random, 2: toggle
    logic rtog    = 1'b0;

    task automatic push(input int m, input logic [AW-1:0] a, input logic [7:0] l, input logic [IDW-1:0] id);
        req_t r;
        r.m = m; r.addr = a; r.len = l; r.id = id;
        pend.push_back(r);
    endtask

    task automatic step();
        logic [NUM_M-1:0] hs;
        @(negedge clk);
        hs = m_arvalid & m_arready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_M; i++) begin
            if (hs[i]) m_arvalid[i] = 1'b0;
            if (!m_arvalid[i]) begin
                for (int j = 0; j < pend.size(); j++) begin
                    if (pend[j].m == i) begin
                        m_arid[i*IDW +: IDW] = pend[j].id;
                        m_araddr[i*AW +: AW] = pend[j].addr;
                        m_arlen[i*8 +: 8]    = pend[j].len;
                        m_arvalid[i]         = 1'b1;
                        pend.delete(j);
                        break;
                    end
                end
            end
        end
        rtog = ~rtog;
        case (rr_mode)
            1:       m_rready = NUM_M'($urandom);
            2:       m_rready = {NUM_M{rtog}};
            default: m_rready = '1;
        endcase
    endtask

    task automatic run(input int nb, input string tag, input int budget);
        int target;
        int n;
        target = bursts_done + nb;
        n = 0;
        while (!(bursts_done >= target && pend.size() == 0 && m_arvalid == '0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, bursts_done >= target, 1);
        step();
        step();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_arvalid = '0;
        pend.delete();
        #1;
        check("arst_s_arvalid", s_arvalid, 0);
        check("arst_m_arready", m_arready, 0);
        check("arst_m_rvalid", m_rvalid, 0);
        check("arst_s_rready", s_rready, 0);
        check("arst_busy", busy, 0);
        check("arst_proto_err", proto_err, 0);
        check("arst_grant_idx", grant_idx, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int g0;
        m_arvalid = '0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_rready  = '1;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[8 + i] = 64'hA0 + 64'(i);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_grant_idx", grant_idx, 0);
        check("reset_proto_err", proto_err, 0);
        check("reset_s_arvalid", s_arvalid, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // single master, 4-beat burst from 0x40
        base = rx_cnt;
        push(0, 32'h40, 8'd3, 4'h5);
        run(1, "single", 200);
        check("single_beats", rx_cnt - base, 4);
        for (int k = 0; k < 4; k++) begin
            check("single_data", rx_data[(base + k) % 1024], 64'hA0 + 64'(k));
            check("single_to_m0", rx_m[(base + k) % 1024], 0);
            check("single_rlast", rx_last[(base + k) % 1024], k == 3);
        end
        check("single_grant", grant_idx, 0);

        // contention right after reset
        pulse_reset();
        g0 = n_grants;
        push(0, 32'h100, 8'd0, 4'h1);
        push(1, 32'h200, 8'd0, 4'h2);
        run(2, "contend", 200);
        check("contend_first", grant_log[g0 % 256], 0);
        check("contend_second", grant_log[(g0 + 1) % 256], 1);

        // fairness with both masters saturated
        g0 = n_grants;
        for (int k = 0; k < 4; k++) begin
            push(0, 32'h300 + 32'(k * 64), 8'(k + 1), 4'h3);
            push(1, 32'h600 + 32'(k * 64), 8'(k), 4'h6);
        end
        run(8, "fair", 1000);
        for (int k = 0; k < 8; k++) check("fair_order", grant_log[(g0 + k) % 256], k % 2);

        // backpressure from M1 toggling rready
        rr_mode = 2;
        base = rx_cnt;
        push(1, 32'h480, 8'd7, 4'h9);
        run(1, "bp", 300);
        rr_mode = 0;
        check("bp_beats", rx_cnt - base, 8);
        for (int k = 0; k < 8; k++) check("bp_to_m1", rx_m[(base + k) % 1024], 1);

        // early rlast then a clean burst
        early_idx = 1;
        base = rx_cnt;
        push(0, 32'h800, 8'd3, 4'hA);
        run(1, "early", 200);
        early_idx = -1;
        check("early_beats", rx_cnt - base, 2);
        check("early_err", proto_err, 1);
        base = rx_cnt;
        push(1, 32'h880, 8'd1, 4'hB);
        run(1, "after_err", 200);
        check("after_err_beats", rx_cnt - base, 2);
        check("err_sticky", proto_err, 1);

        // reset during beat 2 of an 8-beat burst
        base = rx_cnt;
        push(0, 32'hA00, 8'd7, 4'hC);
        for (int n = 0; n < 200 && rx_cnt < base + 1; n++) step();
        check("mid_reached", rx_cnt >= base + 1, 1);
        pulse_reset();
        g0 = n_grants;
        push(1, 32'hB00, 8'd2, 4'hD);
        run(1, "post_rst", 200);
        check("post_rst_grant", grant_log[g0 % 256], 1);
        check("post_rst_idx", grant_idx, 1);

        // randomized traffic with slave stalls and random rready
        gap_mode = 1'b1;
        rr_mode  = 1;
        for (int k = 0; k < 24; k++)
            push(int'($urandom_range(0, NUM_M - 1)), {$urandom} & 32'hFFF8,
                 8'($urandom_range(0, 15)), 4'($urandom));
        run(24, "random", 20000);
        gap_mode = 1'b0;
        rr_mode  = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_ddr_rd_arbiter.md
Name: axi_ddr_rd_arbiter

Overview:
Round-robin arbiter that shares the single-outstanding DDR4 AXI slave's read path (AR/R) among NUM_M read masters, e.g. the MRAM controller refill path and a host/DMA port.
- Grants one master at a time and holds the grant from AR acceptance until the R beat carrying rlast completes.
- Routes R beats back only to the granted master.
- Checks burst length against rlast.
- Sits between the read masters and the DDR slave model's AR/R ports; the write path is not arbitrated here.

Parameters:
NUM_M, 2, number of read masters (legal 2..4)
AXI_ID_WIDTH, 4, ID width, passed through unmodified
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 64, data width
GW, $clog2(NUM_M), grant index width (derived, localparam)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
m_arid  in  NUM_M*AXI_ID_WIDTH  packed per-master ARID, master i at slice i
m_araddr  in  NUM_M*AXI_ADDR_WIDTH  packed ARADDR
m_arlen  in  NUM_M*8  packed ARLEN
m_arvalid  in  NUM_M  per-master ARVALID
m_arready  out  NUM_M  per-master ARREADY
m_rid  out  AXI_ID_WIDTH  RID, shared bus to all masters
m_rdata  out  AXI_DATA_WIDTH  RDATA, shared bus
m_rresp  out  2  RRESP, shared bus
m_rlast  out  1  RLAST, shared bus
m_rvalid  out  NUM_M  per-master RVALID, only the granted bit may be 1
m_rready  in  NUM_M  per-master RREADY
s_arid/s_araddr/s_arlen  out  ID/ADDR/8  to slave AR
s_arvalid  out  1  to slave
s_arready  in  1  from slave
s_rid/s_rdata/s_rresp/s_rlast  in  ID/DATA/2/1  from slave R
s_rvalid  in  1  from slave
s_rready  out  1  to slave
grant_idx  out  GW  current or last granted master
busy  out  1  1 in ADDR or DATA state
proto_err  out  1  sticky burst-length mismatch flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant_idx=0, last_grant=NUM_M-1, beat_cnt=0.
  - s_arvalid=0, m_arready=0, m_rvalid=0, s_rready=0, busy=0, proto_err=0.
  - Reset mid-burst abandons the burst; the slave is reset by the same rst_n.
- States:
  - IDLE: if any m_arvalid=1, select the first requesting master scanning last_grant+1, last_grant+2, … modulo NUM_M. Register grant_idx, go to ADDR. Stay in IDLE if no request.
  - ADDR:
    - s_arvalid=1; s_arid/s_araddr/s_arlen are muxed combinationally from slice grant_idx.
    - m_arready[grant_idx]=s_arready; all other m_arready bits are 0.
    - On s_arvalid&&s_arready: load beat_cnt=arlen+1 (9-bit, range 1..256), go to DATA.
  - DATA:
    - m_rvalid[grant_idx]=s_rvalid; other bits 0. Shared R buses = s_r*. s_rready=m_rready[grant_idx].
    - On each s_rvalid&&s_rready: beat_cnt decrements.
    - On the handshake with s_rlast=1: last_grant<=grant_idx, go to IDLE.
- Outside ADDR/DATA: s_arvalid=0, all m_arready=0, all m_rvalid=0, s_rready=0.
- Latency:
  - AR: m_arvalid in IDLE → s_arvalid on the next cycle; 1 cycle added.
  - R path is combinational, 0 added.
  - At least 1 IDLE cycle between bursts.
- Fairness: with all masters requesting continuously, grants rotate 0,1,…,NUM_M-1,0. A master that is not requesting is skipped with no lost cycle.
- Simultaneous requests in IDLE: the round-robin pointer decides. The first grant after reset goes to master 0.
- Requests arriving during ADDR/DATA wait; AR stability is the masters' obligation under AXI. Requests withdrawn before grant are not supported (AXI violation).
- proto_err is set, and held until reset, when either:
  - s_rlast=1 on a handshake with beat_cnt≠1, or
  - a handshake with beat_cnt=1 has s_rlast=0.
  - In both cases the burst still ends only on s_rlast.
- Non-granted masters' m_rready is ignored.

Test Plan:
- Single master: M0 issues araddr=0x40, arlen=3 to a DDR model (RD_LAT=2) preloaded with 0xA0..0xA3 → s_arvalid 1 cycle after m_arvalid; M0 receives 4 beats 0xA0..0xA3, rlast on beat 4; m_rvalid[1]=0 throughout; grant_idx=0.
- Contention: M0 and M1 both assert arvalid in the same cycle after reset, each arlen=0 → M0 served first; M1's AR is issued the cycle after IDLE follows M0's rlast; m_arready[1]=0 until then.
- Fairness: M0 and M1 continuously request 4 bursts each → grant sequence 0,1,0,1,0,1,0,1; no master is starved.
- Backpressure: M1 granted with arlen=7, m_rready[1] toggles 1,0,1,0 → s_rready mirrors it; all 8 beats are delivered in order; M0 sees no rvalid.
- Protocol check: slave stub returns rlast on beat 2 of an arlen=3 burst → proto_err=1 stays set; state returns to IDLE; the next burst proceeds normally.
- Reset mid-burst: assert rst_n=0 during beat 2 of an arlen=7 burst → all valids/readys go 0 immediately; after release, a new M1-only request is granted (grant_idx=1) and completes.
